// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: round-robin arbiter between two frame producers that
// snapshots the granted frame, starts one led_shifter transfer per frame,
// enforces the WS2812 latch gap and a minimum frame period, and watchdogs
// the shifter.
//
// Handshake: req_x is a level held by the producer until it sees gnt_x.
// gnt_x is a one-cycle pulse; frame_x must stay valid through the gnt_x
// cycle, since the frame is captured at the clock edge that ends it. The
// producer may drop req_x or change frame_x from the following cycle on.
// shift_start is a one-cycle pulse; shift_done is a one-cycle pulse that is
// honoured only while a transfer is in flight.
module led_frame_scheduler #(
  parameter int NUM_LEDS       = 144,
  parameter int FRAME_CYCLES   = 800000,
  parameter int LATCH_CYCLES   = 14400,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_a,
  input  logic [24*NUM_LEDS-1:0]  frame_a,
  input  logic                    req_b,
  input  logic [24*NUM_LEDS-1:0]  frame_b,
  output logic                    gnt_a,
  output logic                    gnt_b,
  output logic [24*NUM_LEDS-1:0]  color_string,
  output logic                    shift_start,
  input  logic                    shift_done,
  output logic                    busy,
  output logic                    err,
  output logic [15:0]             frame_count,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_SHIFT = 3'd4,
    S_LATCH = 3'd5
  } state_t;

  // The period counter holds the number of cycles since the last shift_start.
  // IDLE->ARB->LOAD->START adds three cycles after the IDLE decision, so the
  // gate opens three cycles early; successive shift_start pulses then land
  // exactly FRAME_CYCLES apart when a request is already waiting.
  localparam logic [31:0] PERIOD_MAX   = 32'(FRAME_CYCLES);
  localparam logic [31:0] PERIOD_OK_AT = (FRAME_CYCLES > 3) ? 32'(FRAME_CYCLES - 3) : 32'd0;
  localparam logic [31:0] WD_LAST      = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] LATCH_LAST   = 32'(LATCH_CYCLES - 1);

  state_t                   r_state;
  logic                     r_sel_b;
  logic                     r_last_a;
  logic                     r_gnt_a;
  logic                     r_gnt_b;
  logic [24*NUM_LEDS-1:0]   r_color;
  logic                     r_shift_start;
  logic                     r_busy;
  logic                     r_err;
  logic [15:0]              r_frame_count;
  logic [31:0]              r_period;
  logic [31:0]              r_wd;
  logic [31:0]              r_latch;
  logic                     w_period_ok;

  assign w_period_ok = (r_period >= PERIOD_OK_AT);

  // Saturating cycles-since-shift_start counter; starts saturated so the
  // first frame after reset is not delayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= PERIOD_MAX;
    end else if (r_state == S_START) begin
      r_period <= 32'd1;
    end else if (r_period < PERIOD_MAX) begin
      r_period <= r_period + 32'd1;
    end
  end

  // Main sequencer: arbitration, frame snapshot, shifter start, watchdog and
  // latch gap, with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sel_b       <= 1'b0;
      r_last_a      <= 1'b0;  // "last was B" so A wins the first tie
      r_gnt_a       <= 1'b0;
      r_gnt_b       <= 1'b0;
      r_color       <= '0;
      r_shift_start <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_frame_count <= 16'd0;
      r_wd          <= 32'd0;
      r_latch       <= 32'd0;
    end else begin
      r_gnt_a       <= 1'b0;
      r_gnt_b       <= 1'b0;
      r_shift_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if ((req_a || req_b) && w_period_ok) begin
            r_state <= S_ARB;
            r_busy  <= 1'b1;
          end
        end
        S_ARB: begin
          // Requests are re-sampled here; one dropped since IDLE is not granted.
          if (req_a && req_b) begin
            r_sel_b <= r_last_a;
            r_gnt_a <= ~r_last_a;
            r_gnt_b <= r_last_a;
            r_state <= S_LOAD;
          end else if (req_a) begin
            r_sel_b <= 1'b0;
            r_gnt_a <= 1'b1;
            r_state <= S_LOAD;
          end else if (req_b) begin
            r_sel_b <= 1'b1;
            r_gnt_b <= 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_color       <= r_sel_b ? frame_b : frame_a;
          r_last_a      <= ~r_sel_b;
          r_shift_start <= 1'b1;
          r_state       <= S_START;
        end
        S_START: begin
          r_wd    <= 32'd1;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (shift_done) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_latch       <= 32'd0;
            r_state       <= S_LATCH;
          end else if (r_wd >= WD_LAST) begin
            r_err   <= 1'b1;
            r_latch <= 32'd0;
            r_state <= S_LATCH;
          end else begin
            r_wd <= r_wd + 32'd1;
          end
        end
        S_LATCH: begin
          if (r_latch >= LATCH_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_latch <= r_latch + 32'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_a        = r_gnt_a;
  assign gnt_b        = r_gnt_b;
  assign color_string = r_color;
  assign shift_start  = r_shift_start;
  assign busy         = r_busy;
  assign err          = r_err;
  assign frame_count  = r_frame_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Testbench for led_frame_scheduler: directed table of arbitration vectors
// plus hand-written sequences for latency, period, freeze, watchdog, async
// reset and frame counter wrap.
module tb_led_frame_scheduler;

  localparam int NUM_LEDS = 144;
  localparam int W        = 24 * NUM_LEDS;
  localparam int FRAME    = 200;
  localparam int LATCH    = 20;
  localparam int TIMEOUT  = 100;
  localparam int DONE_DLY = 50;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_a = 1'b0;
  logic           req_b = 1'b0;
  logic [W-1:0]   frame_a = '0;
  logic [W-1:0]   frame_b = '0;
  logic           shift_done = 1'b0;
  logic           gnt_a, gnt_b, shift_start, busy, err;
  logic [W-1:0]   color_string;
  logic [15:0]    frame_count;
  logic [2:0]     dbg_state;

  led_frame_scheduler #(
    .NUM_LEDS(NUM_LEDS), .FRAME_CYCLES(FRAME),
    .LATCH_CYCLES(LATCH), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .frame_a(frame_a),
    .req_b(req_b), .frame_b(frame_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .color_string(color_string), .shift_start(shift_start),
    .shift_done(shift_done), .busy(busy), .err(err),
    .frame_count(frame_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, act=hung req=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- counters / scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int both_cnt = 0;
  int start_run_cnt = 0;
  logic prev_start = 1'b0;
  logic [0:0] exp_q[$];

  // Shifter model: one-cycle shift_done DONE_DLY cycles after shift_start.
  bit model_en = 1'b1;
  bit m_run = 1'b0;
  int m_ticks = 0;
  always @(negedge clk) begin
    shift_done = 1'b0;
    if (rst) begin
      m_run = 1'b0;
    end else if (shift_start) begin
      m_run   = 1'b1;
      m_ticks = 0;
    end else if (m_run) begin
      m_ticks++;
      if (m_ticks == DONE_DLY) begin
        m_run = 1'b0;
        if (model_en) shift_done = 1'b1;
      end
    end
  end

  // Protocol monitor: never both grants, shift_start never two cycles wide.
  always @(negedge clk) begin
    if (gnt_a && gnt_b) both_cnt++;
    if (shift_start && prev_start) start_run_cnt++;
    prev_start = shift_start;
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: act=%0h req=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_frame(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: act[63:0]=%h req[63:0]=%h (cycle %0d)", name, act[63:0], exp[63:0], cyc);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (gnt_a || gnt_b) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      if (!busy) return;
      step();
    end
    tests++;
    fails++;
    $display("FAIL wait_idle: act=busy req=idle within 400 cycles (cycle %0d)", cyc);
  endtask

  function automatic logic [W-1:0] mk_frame(input int seed);
    logic [W-1:0] f;
    for (int k = 0; k < NUM_LEDS; k++) f[k*24 +: 24] = 24'(seed * 40503 + k * 97);
    return f;
  endfunction

  typedef struct {
    logic ra;
    logic rb;
    logic exp_a;
    logic exp_b;
  } vec_t;

  vec_t vecs[8];

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] p, fa, fb, x;
    logic [143:0] unit;
    bit ok;
    int g, s, c1, bl, bad;
    logic bz, ga, gb;
    logic [W-1:0] cs;
    int starts[$];

    // rr starts favouring A; each row leaves the pointer on the granted side.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state
    repeat (2) step();
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_shift_start", shift_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_dbg_state", dbg_state, 0);
    chk_frame("rst_color", color_string, '0);
    rst = 1'b0;
    step();

    // First frame latency
    unit = {24'h00CEFF, 24'h00CEFF, 24'h00CEFF, 72'h0};
    p = {24{unit}};
    frame_a = p;
    req_a = 1'b1;
    g = -1; s = -1; c1 = -1; bl = -1; bz = 1'b0; cs = '0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (gnt_a && g < 0) begin g = k; bz = busy; req_a = 1'b0; end
      if (shift_start && s < 0) begin s = k; cs = color_string; end
      if (frame_count == 16'd1 && c1 < 0) c1 = k;
      if (s > 0 && !busy && bl < 0) bl = k;
    end
    chk("first_gnt_cycle", g, 2);
    chk("first_start_cycle", s, 3);
    chk("first_busy_at_gnt", bz, 1);
    chk_frame("first_color", cs, p);
    chk("first_count_cycle", c1, 3 + DONE_DLY + 1);
    chk("first_busy_low_cycle", bl, 3 + DONE_DLY + 1 + LATCH);
    chk("first_frame_count", frame_count, 1);
    chk("first_err", err, 0);

    // Table-driven arbitration vectors
    do_reset();
    for (int i = 0; i < 8; i++) begin
      fa = mk_frame(100 + i);
      fb = mk_frame(200 + i);
      frame_a = fa;
      frame_b = fb;
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      wait_gnt(ok);
      chk($sformatf("tbl%0d_gnt_seen", i), ok, 1);
      chk($sformatf("tbl%0d_gnt_a", i), gnt_a, vecs[i].exp_a);
      chk($sformatf("tbl%0d_gnt_b", i), gnt_b, vecs[i].exp_b);
      req_a = 1'b0;
      req_b = 1'b0;
      step();
      chk($sformatf("tbl%0d_start", i), shift_start, 1);
      wait_idle();
      chk_frame($sformatf("tbl%0d_color", i), color_string, vecs[i].exp_b ? fb : fa);
      chk($sformatf("tbl%0d_count", i), frame_count, i + 1);
    end

    // Both requests held: alternation and exact frame period
    do_reset();
    frame_a = mk_frame(11);
    frame_b = mk_frame(12);
    req_a = 1'b1;
    req_b = 1'b1;
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    starts = {};
    for (int k = 0; k < 1000 && starts.size() < 4; k++) begin
      step();
      if (gnt_a || gnt_b) begin
        if (exp_q.size() > 0) chk("alt_side", gnt_b, exp_q.pop_front());
        else chk("alt_extra_grant", 1, 0);
      end
      if (shift_start) starts.push_back(cyc);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    chk("alt_starts_seen", starts.size(), 4);
    chk("alt_grants_left", exp_q.size(), 0);
    for (int i = 1; i < starts.size(); i++)
      chk($sformatf("alt_period%0d", i), starts[i] - starts[i-1], FRAME);
    wait_idle();

    // Frame inputs churn during SHIFT/LATCH: snapshot must hold
    x = mk_frame(21);
    frame_a = x;
    req_a = 1'b1;
    wait_gnt(ok);
    chk("freeze_gnt_a", gnt_a, 1);
    req_a = 1'b0;
    step();
    bad = 0;
    for (int k = 0; k < 300 && busy; k++) begin
      for (int j = 0; j < W / 32; j++) begin
        frame_a[j*32 +: 32] = $urandom;
        frame_b[j*32 +: 32] = $urandom;
      end
      step();
      if (color_string !== x) bad++;
    end
    chk("freeze_bad_cycles", bad, 0);
    chk_frame("freeze_final", color_string, x);

    // Watchdog: shifter never answers
    do_reset();
    model_en = 1'b0;
    frame_a = mk_frame(31);
    req_a = 1'b1;
    wait_gnt(ok);
    chk("wd_gnt_a", gnt_a, 1);
    req_a = 1'b0;
    step();
    chk("wd_start", shift_start, 1);
    for (int k = 1; k <= TIMEOUT + LATCH; k++) begin
      step();
      if (k == TIMEOUT - 1) chk("wd_err_before", err, 0);
      if (k == TIMEOUT) chk("wd_err_at_timeout", err, 1);
      if (k == TIMEOUT + LATCH - 1) chk("wd_busy_in_latch", busy, 1);
      if (k == TIMEOUT + LATCH) chk("wd_busy_after_latch", busy, 0);
    end
    chk("wd_count_unchanged", frame_count, 0);
    model_en = 1'b1;
    frame_b = mk_frame(32);
    req_b = 1'b1;
    wait_gnt(ok);
    chk("wd_next_gnt_b", gnt_b, 1);
    req_b = 1'b0;
    wait_idle();
    chk("wd_next_count", frame_count, 1);
    chk("wd_err_sticky", err, 1);
    chk_frame("wd_next_color", color_string, mk_frame(32));

    // Async reset mid-SHIFT after an A grant
    frame_a = mk_frame(41);
    req_a = 1'b1;
    wait_gnt(ok);
    chk("arst_gnt_a", gnt_a, 1);
    req_a = 1'b0;
    step();
    chk("arst_start", shift_start, 1);
    repeat (25) step();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_count", frame_count, 0);
    chk("arst_dbg_state", dbg_state, 0);
    chk("arst_gnts", {gnt_a, gnt_b, shift_start}, 0);
    chk_frame("arst_color", color_string, '0);
    step();
    step();
    rst = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    g = -1; ga = 1'b0; gb = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if ((gnt_a || gnt_b) && g < 0) begin
        g = k; ga = gnt_a; gb = gnt_b;
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    chk("arst_regrant_cycle", g, 2);
    chk("arst_regrant_a", ga, 1);
    chk("arst_regrant_b", gb, 0);
    wait_idle();
    chk("arst_post_count", frame_count, 1);

    // frame_count wrap 0xFFFF -> 0
    force dut.r_frame_count = 16'hFFFF;
    step();
    release dut.r_frame_count;
    step();
    frame_a = mk_frame(51);
    req_a = 1'b1;
    wait_gnt(ok);
    chk("wrap_gnt_seen", ok, 1);
    req_a = 1'b0;
    wait_idle();
    chk("wrap_count", frame_count, 0);

    chk("never_both_gnt", both_cnt, 0);
    chk("start_single_cycle", start_run_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
